// File: rtl/fmc_pkg.sv
// Shared types and default widths for the FMC burst engine.
package fmc_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } fmc_state_e;

endpackage

// File: rtl/fmc_fifo.sv
// Synchronous beat FIFO with flush and occupancy count; Depth must be a power of two.
module fmc_fifo #(
    parameter int Width = 16,
    parameter int Depth = 4,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Beat storage has no reset; the pointers decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
    end

    // Pointer and occupancy bookkeeping; a flush overrides push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fmc_burst_engine.sv
// FMC burst engine: turns FMC write/read bursts into single-beat memory requests.
// Optional FMC_BURST_STATS_EN adds saturating burst and dropped-beat counters.
module fmc_burst_engine
    import fmc_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_W,
    parameter int AddrWidth = DEF_ADDR_W,
    parameter int FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 burst_start_i,
    input  logic [AddrWidth-1:0] burst_addr_i,
    input  logic                 burst_we_i,
    input  logic                 burst_end_i,
    input  logic                 wr_valid_i,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic                 wr_full_o,
    input  logic                 rd_pop_i,
    output logic [DataWidth-1:0] rd_data_o,
    output logic                 rd_empty_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 busy_o
`ifdef FMC_BURST_STATS_EN
    ,
    output logic [15:0]          stat_bursts_o,
    output logic [15:0]          stat_drops_o
`endif
);

    localparam int CntW = $clog2(FifoDepth) + 1;
    localparam logic [CntW:0] DepthCnt = (CntW + 1)'(FifoDepth);

    fmc_state_e           state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [CntW-1:0]      osd_q;
    logic                 end_q, end_d;
    logic                 hold_q, hold_d;
    logic                 load_addr;
    logic                 rd_issue, rd_retire;
    logic [CntW:0]        inflight;

    logic                 wr_push, wr_pop, wr_flush, wr_full, wr_empty;
    logic [DataWidth-1:0] wr_head;
    logic [CntW-1:0]      wr_cnt;
    logic                 rd_push, rd_flush, rd_full, rd_empty;
    logic [CntW-1:0]      rd_cnt;

    fmc_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_wr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (wr_flush),
        .push_i  (wr_push),
        .data_i  (wr_data_i),
        .pop_i   (wr_pop),
        .data_o  (wr_head),
        .full_o  (wr_full),
        .empty_o (wr_empty),
        .count_o (wr_cnt)
    );

    fmc_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_rd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (rd_flush),
        .push_i  (rd_push),
        .data_i  (mem_rdata_i),
        .pop_i   (rd_pop_i),
        .data_o  (rd_data_o),
        .full_o  (rd_full),
        .empty_o (rd_empty),
        .count_o (rd_cnt)
    );

    // Reads already in the FIFO plus reads still in flight bound the prefetch window.
    assign inflight    = {1'b0, rd_cnt} + {1'b0, osd_q};
    assign rd_issue    = mem_req_o && !mem_we_o && mem_gnt_i;
    assign rd_retire   = mem_rvalid_i && (osd_q != '0);
    assign end_d       = (state_d == ST_WRITE) && (end_q || burst_end_i);
    assign wr_full_o   = wr_full;
    assign rd_empty_o  = rd_empty;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wr_head;
    assign busy_o      = (state_q != ST_IDLE);

    // Next-state, memory request and FIFO control decode.
    always_comb begin
        state_d   = state_q;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        hold_d    = 1'b0;
        load_addr = 1'b0;
        wr_flush  = 1'b0;
        rd_flush  = 1'b0;
        wr_push   = 1'b0;
        wr_pop    = 1'b0;
        rd_push   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // An end pulse in the same cycle cancels the start.
                if (burst_start_i && !burst_end_i) begin
                    load_addr = 1'b1;
                    wr_flush  = 1'b1;
                    rd_flush  = 1'b1;
                    state_d   = burst_we_i ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wr_push = wr_valid_i;
                if (!wr_empty) begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                    wr_pop    = mem_gnt_i;
                end
                // Leave only once every accepted beat has been written out.
                if ((end_q || burst_end_i) && (wr_cnt == '0) && !wr_valid_i) state_d = ST_IDLE;
            end
            ST_READ: begin
                rd_push = rd_retire;
                if ((inflight < DepthCnt) && !rd_full) mem_req_o = 1'b1;
                if (burst_end_i) begin
                    // A request already on the bus must be kept until granted.
                    hold_d  = mem_req_o && !mem_gnt_i;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                mem_req_o = hold_q;
                hold_d    = hold_q && !mem_gnt_i;
                if (!hold_q && (osd_q == '0)) begin
                    rd_flush = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Address counter, outstanding-read count and the end/hold flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            osd_q  <= '0;
            end_q  <= 1'b0;
            hold_q <= 1'b0;
        end else begin
            end_q  <= end_d;
            hold_q <= hold_d;
            if (load_addr)                   addr_q <= burst_addr_i;
            else if (mem_req_o && mem_gnt_i) addr_q <= addr_q + 1'b1;
            case ({rd_issue, rd_retire})
                2'b10:   osd_q <= osd_q + 1'b1;
                2'b01:   osd_q <= osd_q - 1'b1;
                default: osd_q <= osd_q;
            endcase
        end
    end

`ifdef FMC_BURST_STATS_EN
    logic        burst_done;
    logic        beat_drop;
    logic [15:0] bursts_q;
    logic [15:0] drops_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign burst_done    = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    assign beat_drop     = (state_q == ST_WRITE) && wr_valid_i && wr_full;
    assign stat_bursts_o = bursts_q;
    assign stat_drops_o  = drops_q;

    // Saturating counters of completed bursts and write beats lost to a full FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bursts_q <= '0;
            drops_q  <= '0;
        end else begin
            if (burst_done) bursts_q <= sat_inc(bursts_q);
            if (beat_drop)  drops_q  <= sat_inc(drops_q);
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fmc_burst_engine.sv
// Self-checking bench for fmc_burst_engine with a behavioural memory and burst model.
module tb_fmc_burst_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        burst_start_i, burst_we_i, burst_end_i;
    logic [15:0] burst_addr_i;
    logic        wr_valid_i;
    logic [15:0] wr_data_i;
    logic        wr_full_o;
    logic        rd_pop_i;
    logic [15:0] rd_data_o;
    logic        rd_empty_o;
    logic        mem_req_o, mem_we_o;
    logic [15:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [15:0] mem_rdata_i;
    logic        busy_o;

    always #5 clk = ~clk;

    fmc_burst_engine #(.DataWidth(16), .AddrWidth(16), .FifoDepth(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .burst_start_i (burst_start_i),
        .burst_addr_i  (burst_addr_i),
        .burst_we_i    (burst_we_i),
        .burst_end_i   (burst_end_i),
        .wr_valid_i    (wr_valid_i),
        .wr_data_i     (wr_data_i),
        .wr_full_o     (wr_full_o),
        .rd_pop_i      (rd_pop_i),
        .rd_data_o     (rd_data_o),
        .rd_empty_o    (rd_empty_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .busy_o        (busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    typedef struct { int due; logic [15:0] data; } resp_t;
    resp_t       pend[$];
    logic [15:0] resp_mem [0:65535];
    int          cyc = 0;
    int          lat = 1;
    bit          gnt_en = 1'b1;

    initial begin
        resp_t r;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            mem_gnt_i = gnt_en;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                r = pend.pop_front();
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = r.data;
            end else begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = '0;
            end
            if (mem_req_o && mem_gnt_i) begin
                if (mem_we_o) resp_mem[mem_addr_o] = mem_wdata_o;
                else begin
                    r.due  = cyc + lat;
                    r.data = resp_mem[mem_addr_o];
                    pend.push_back(r);
                end
            end
        end
    end

    // ---------------- behavioural burst model ----------------
    typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] exp_rd_addr = '0;
    int          rd_req_cnt = 0;

    task automatic model_write(input logic [15:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
        ref_mem[a] = d;
    endtask

    // Single compare process: every granted request and every accepted pop.
    logic        prev_ok = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
    logic [15:0] prev_addr = '0, prev_wdata = '0;

    always @(negedge clk) begin
        wr_t w;
        if (rst_n) begin
            if (prev_ok && prev_req && !prev_gnt) begin
                check("req_hold", mem_req_o, 1'b1);
                check("req_hold_addr", mem_addr_o, prev_addr);
                check("req_hold_we", mem_we_o, prev_we);
                if (prev_we) check("req_hold_wdata", mem_wdata_o, prev_wdata);
            end
            if (mem_req_o && mem_gnt_i) begin
                if (mem_we_o) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected addr=%h data=%h", mem_addr_o, mem_wdata_o);
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", mem_addr_o, w.addr);
                        check("wr_data", mem_wdata_o, w.data);
                    end
                end else begin
                    check("rd_addr", mem_addr_o, exp_rd_addr);
                    exp_rd_addr = exp_rd_addr + 16'd1;
                    rd_req_cnt++;
                end
            end
            if (rd_pop_i && !rd_empty_o) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected data=%h", rd_data_o);
                end else check("rd_data", rd_data_o, exp_rd.pop_front());
            end
        end
        prev_ok    = rst_n;
        prev_req   = mem_req_o;
        prev_gnt   = mem_gnt_i;
        prev_we    = mem_we_o;
        prev_addr  = mem_addr_o;
        prev_wdata = mem_wdata_o;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
        check(name, busy_o, 1'b0);
    endtask

    task automatic start_burst(input logic [15:0] a, input logic we);
        tick();
        burst_start_i = 1'b1;
        burst_addr_i  = a;
        burst_we_i    = we;
    endtask

    task automatic do_write2(input string name, input logic [15:0] a, input logic [15:0] d0, input logic [15:0] d1);
        model_write(a, d0);
        model_write(a + 16'd1, d1);
        start_burst(a, 1'b1);
        tick(); burst_start_i = 1'b0; wr_valid_i = 1'b1; wr_data_i = d0;
        tick(); wr_data_i = d1;
        tick(); wr_valid_i = 1'b0; burst_end_i = 1'b1;
        tick(); burst_end_i = 1'b0;
        wait_idle(name, 30);
        check({name, "_all_written"}, exp_wr.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req"}, mem_req_o, 1'b0);
        check({name, "_wr_full"}, wr_full_o, 1'b0);
        check({name, "_rd_empty"}, rd_empty_o, 1'b1);
        check({name, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        rst_n = 1'b0;
        burst_start_i = 1'b0; burst_we_i = 1'b0; burst_end_i = 1'b0; burst_addr_i = '0;
        wr_valid_i = 1'b0; wr_data_i = '0; rd_pop_i = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            resp_mem[i] = 16'(i) ^ 16'h5A5A;
            ref_mem[i]  = 16'(i) ^ 16'h5A5A;
        end
        repeat (3) @(posedge clk);
        sample();
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;

        // Write burst at 0x1234 with a start pulse mid-burst that must be ignored.
        gnt_en = 1'b1;
        model_write(16'h1234, 16'h6789);
        model_write(16'h1235, 16'hABCD);
        model_write(16'h1236, 16'hABAC);
        start_burst(16'h1234, 1'b1);
        tick(); burst_start_i = 1'b0; wr_valid_i = 1'b1; wr_data_i = 16'h6789;
        tick(); wr_data_i = 16'hABCD; burst_start_i = 1'b1; burst_we_i = 1'b0; burst_addr_i = 16'h9999;
        tick(); burst_start_i = 1'b0; wr_data_i = 16'hABAC;
        tick(); wr_valid_i = 1'b0; burst_end_i = 1'b1;
        tick(); burst_end_i = 1'b0;
        wait_idle("wr1234_idle", 30);
        check("wr1234_all_written", exp_wr.size(), 0);
        check("wr1234_mem0", resp_mem[16'h1234], 16'h6789);
        check("wr1234_mem2", resp_mem[16'h1236], 16'hABAC);

        // Read burst at 0x1235, latency 2: three empty cycles then ABCD, ABAC.
        lat = 2;
        exp_rd_addr = 16'h1235;
        exp_rd.push_back(ref_mem[16'h1235]);
        exp_rd.push_back(ref_mem[16'h1236]);
        start_burst(16'h1235, 1'b0);
        tick(); burst_start_i = 1'b0;
        sample(); check("rd_lat_c1_empty", rd_empty_o, 1'b1);
        check("rd_first_req", mem_req_o, 1'b1);
        tick(); sample(); check("rd_lat_c2_empty", rd_empty_o, 1'b1);
        tick(); sample(); check("rd_lat_c3_empty", rd_empty_o, 1'b1);
        tick(); sample(); check("rd_lat_c4_empty", rd_empty_o, 1'b0);
        check("rd_head_abcd", rd_data_o, 16'hABCD);
        tick(); rd_pop_i = 1'b1;
        tick(); sample(); check("rd_head_abac", rd_data_o, 16'hABAC);
        tick(); rd_pop_i = 1'b0; burst_end_i = 1'b1;
        tick(); burst_end_i = 1'b0;
        wait_idle("rd1235_idle", 30);
        check("rd1235_flushed", rd_empty_o, 1'b1);
        check("rd1235_all_popped", exp_rd.size(), 0);

        // Prefetch with no pops stops at exactly FifoDepth requests.
        lat = 1;
        exp_rd_addr = 16'h2000;
        base = rd_req_cnt;
        start_burst(16'h2000, 1'b0);
        tick(); burst_start_i = 1'b0;
        repeat (10) tick();
        sample();
        check("prefetch_count", rd_req_cnt - base, 4);
        check("prefetch_req_low", mem_req_o, 1'b0);
        tick(); burst_end_i = 1'b1;
        tick(); burst_end_i = 1'b0;
        wait_idle("prefetch_idle", 30);
        check("prefetch_flushed", rd_empty_o, 1'b1);

        // Address wrap at the top of the space.
        do_write2("wrap", 16'hFFFF, 16'h1111, 16'h2222);
        check("wrap_mem_top", resp_mem[16'hFFFF], 16'h1111);
        check("wrap_mem_zero", resp_mem[16'h0000], 16'h2222);

        // Start and end together in IDLE: end wins.
        start_burst(16'h7777, 1'b1);
        burst_end_i = 1'b1;
        tick(); burst_start_i = 1'b0; burst_end_i = 1'b0;
        sample();
        check("start_end_busy", busy_o, 1'b0);
        check("start_end_req", mem_req_o, 1'b0);

        // End with two reads outstanding: drain discards both.
        lat = 4;
        exp_rd_addr = 16'h3000;
        start_burst(16'h3000, 1'b0);
        tick(); burst_start_i = 1'b0;
        tick(); burst_end_i = 1'b1;
        tick(); burst_end_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("drain_busy", busy_o, 1'b1);
            check("drain_no_req", mem_req_o, 1'b0);
            check("drain_empty", rd_empty_o, 1'b1);
            tick();
        end
        wait_idle("drain_idle", 30);
        check("drain_flushed", rd_empty_o, 1'b1);
        check("drain_resp_done", pend.size(), 0);

        // End while a request is stalled: it stays up until granted.
        lat = 1;
        gnt_en = 1'b0;
        exp_rd_addr = 16'h5000;
        start_burst(16'h5000, 1'b0);
        tick(); burst_start_i = 1'b0; burst_end_i = 1'b1;
        tick(); burst_end_i = 1'b0;
        sample();
        check("held_req", mem_req_o, 1'b1);
        check("held_addr", mem_addr_o, 16'h5000);
        tick(); gnt_en = 1'b1;
        wait_idle("held_idle", 30);
        check("held_flushed", rd_empty_o, 1'b1);

        // Reset mid read: late responses in IDLE are discarded.
        lat = 3;
        exp_rd_addr = 16'h6000;
        start_burst(16'h6000, 1'b0);
        tick(); burst_start_i = 1'b0;
        tick();
        tick(); rst_n = 1'b0;
        sample();
        check_reset_outputs("rst_rd");
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("rst_rd_discard", rd_empty_o, 1'b1);
            tick();
        end

        // Reset mid write with a stalled, full FIFO; next burst starts cleanly.
        gnt_en = 1'b0;
        start_burst(16'h0500, 1'b1);
        tick(); burst_start_i = 1'b0; wr_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data_i = 16'hC000 + 16'(i);
            tick();
        end
        wr_valid_i = 1'b0;
        sample();
        check("full_flag", wr_full_o, 1'b1);
        check("full_req", mem_req_o, 1'b1);
        tick(); rst_n = 1'b0;
        sample();
        check_reset_outputs("rst_wr");
        tick(); rst_n = 1'b1; gnt_en = 1'b1;
        do_write2("after_rst", 16'h0010, 16'h5151, 16'h6262);
        check("after_rst_mem", resp_mem[16'h0010], 16'h5151);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
